// File: rtl/axi_stream_rr_arbiter.sv
// Round-robin N-to-1 AXI-Stream arbiter with a one-entry registered output buffer.
// Define ARB_TID_EN to add the tid_o source-index output.
module axi_stream_rr_arbiter #(
    parameter int unsigned SRC_NUM    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned SEL_WIDTH  = $clog2(SRC_NUM)
) (
    input  logic                  aclk_i,
    input  logic                  aresetn_i,
    input  logic [DATA_WIDTH-1:0] tdata_i  [0:SRC_NUM-1],
    input  logic [ADDR_WIDTH-1:0] taddr_i  [0:SRC_NUM-1],
    input  logic [SRC_NUM-1:0]    tvalid_i,
    output logic [SRC_NUM-1:0]    tready_o,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic [ADDR_WIDTH-1:0] taddr_o,
    output logic                  tvalid_o,
`ifdef ARB_TID_EN
    output logic [SEL_WIDTH-1:0]  tid_o,
`endif
    input  logic                  tready_i
);

    logic [DATA_WIDTH-1:0] tdata_q;
    logic [ADDR_WIDTH-1:0] taddr_q;
    logic                  tvalid_q;
    logic [SEL_WIDTH-1:0]  last_q;

    logic                  load_ok;
    logic                  grant_found;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic                  load;
    int unsigned           cand;
    logic [SEL_WIDTH-1:0]  cand_sel;

    assign load_ok = !tvalid_q || tready_i;

    // Search starts one past the last winner and ends on the last winner itself.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_sel    = '0;
        for (int unsigned i = 1; i <= SRC_NUM; i++) begin
            cand     = (32'(last_q) + i) % SRC_NUM;
            cand_sel = SEL_WIDTH'(cand);
            if (!grant_found && tvalid_i[cand_sel]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sel;
            end
        end
    end

    assign load = load_ok && grant_found;

    always_comb begin
        tready_o = '0;
        if (load && aresetn_i) begin
            tready_o[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            tdata_q  <= '0;
            taddr_q  <= '0;
            tvalid_q <= 1'b0;
            last_q   <= SEL_WIDTH'(SRC_NUM - 1);
        end else if (load) begin
            tdata_q  <= tdata_i[grant_idx];
            taddr_q  <= taddr_i[grant_idx];
            tvalid_q <= 1'b1;
            last_q   <= grant_idx;
        end else if (tready_i) begin
            // Drain with nothing to replace it: data/addr keep their last value.
            tvalid_q <= 1'b0;
        end
    end

`ifdef ARB_TID_EN
    logic [SEL_WIDTH-1:0] tid_q;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            tid_q <= '0;
        end else if (load) begin
            tid_q <= grant_idx;
        end
    end

    assign tid_o = tid_q;
`endif

    assign tdata_o  = tdata_q;
    assign taddr_o  = taddr_q;
    assign tvalid_o = tvalid_q;

endmodule
